fir_tap_sequencer: RTL
======================

Name: fir_tap_sequencer

Overview:
Upstream control stage for the FIR MAC block (dsp). It accepts incoming 24-bit audio samples and shifts each one into an NTAPS-deep 16-bit sample window. For each accepted sample it steps through every tap index, driving the tap coefficient, the tap index and the MAC enable that dsp consumes. Coefficients are read from a per-band coefficient ROM selected by the equalizer setting eq_sel_i.

Parameters:
NTAPS, 10, number of FIR taps and depth of the sample window
NBANDS, 4, number of equalizer coefficient sets held in the ROM
SAMPLE_W, 24, width of the incoming sample
DATA_W, 16, width of window words and coefficients

Ports:
clk_i  in  1  system clock; all state updates on the rising edge
rst_i  in  1  synchronous, active-high reset
sample_valid_i  in  1  single-cycle strobe: sample_i is valid this cycle
sample_i  in  SAMPLE_W  incoming sample; only bits [23:8] are used
eq_sel_i  in  8  equalizer band select; sampled when a sample is accepted
signal_window_o  out  NTAPS x DATA_W  window; index 0 holds the newest sample
tap_o  out  DATA_W  coefficient for tapnum_o (signed Q15)
tapnum_o  out  8  current tap index
mac_en_o  out  1  high while tap_o/tapnum_o are valid; drives dsp clk_en_i
busy_o  out  1  high whenever the FSM is not in IDLE
frame_done_o  out  1  one-cycle pulse after the last tap of a frame
dropped_o  out  1  one-cycle pulse when a sample arrives while busy_o=1

Behaviour:
- Clocking and reset: one clock, clk_i. rst_i is synchronous and active-high and dominates every other input.
- Reset values: state=IDLE, every window word 0, tap_o=0, tapnum_o=0, mac_en_o=0, busy_o=0, frame_done_o=0, dropped_o=0.
- FSM states: IDLE, PRIME, RUN, DONE.
- IDLE, sample_valid_i=1:
  - shift the window: word k takes word k-1; word 0 takes sample_i[23:8]; the old word NTAPS-1 is discarded.
  - latch the band: min(eq_sel_i, NBANDS-1).
  - ROM address = (band, tap 0); go to PRIME.
- PRIME: one cycle to cover the ROM's 1-cycle read latency. Tap counter = 0. Go to RUN.
- RUN:
  - mac_en_o=1, tapnum_o=counter, tap_o=COEFF[band][counter].
  - the ROM is pre-addressed one cycle ahead so one tap is produced per cycle.
  - when counter = NTAPS-1, go to DONE; otherwise increment the counter.
- DONE: frame_done_o=1 for one cycle, mac_en_o=0, go to IDLE.
- Latency, with the sample accepted at edge T:
  - window updated after T.
  - first tap (tapnum_o=0) is presented in cycle T+2.
  - last tap (tapnum_o=NTAPS-1) is presented in cycle T+NTAPS+1.
  - frame_done_o pulses in cycle T+NTAPS+2.
  - busy_o is high from T+1 through T+NTAPS+2.
  - maximum rate is one sample per NTAPS+3 cycles.
- Outside RUN, tap_o and tapnum_o hold their last values and mac_en_o=0.
- signal_window_o and the latched band must stay stable from PRIME through DONE, because dsp reads them throughout the frame.
- A sample arriving while busy_o=1, including in DONE: it is ignored, dropped_o pulses, and the window, band and FSM are unaffected.
- eq_sel_i changing mid-frame has no effect until the next accepted sample.
- rst_i asserted mid-frame: the next cycle is IDLE with the window cleared; no frame_done_o pulse for the aborted frame.
- Arithmetic: the tap counter is 8 bits wide and never wraps, since it stops at NTAPS-1. No arithmetic is applied to the data path.

Decomposition:
- Shared package fir_pkg holds:
  - NTAPS_DEF, NBANDS_DEF, DATA_W_DEF.
  - enum seq_state_t {IDLE, PRIME, RUN, DONE}.
  - constant array COEFF[NBANDS][NTAPS] of signed Q15 values:
    - band 0: 16'h7FFF at tap 0, 0 elsewhere (pass-through).
    - band 1: 16'h0CCD at every tap (moving average).
    - band 2: 16'h4000 at taps 0 and 1, 0 elsewhere.
    - band 3: 16'h2000 at every tap.
- One sub-module, fir_coeff_rom: synchronous-read ROM with addr = {band, tap}, 1-cycle latency, contents taken from COEFF.

Test Plan:
- Reset: hold rst_i=1 for 1 cycle with random inputs -> next cycle every output is 0 and busy_o=0.
- Single frame: sample_i=24'h000400, eq_sel_i=0 at T -> signal_window_o[0]=16'h0004 at T+1; tapnum_o steps 0..9 over T+2..T+11 with tap_o=7FFF then 0000; mac_en_o high for exactly 10 cycles; frame_done_o at T+12.
- Window ordering: feed 11 frames with samples 24'h000100, 000200, …, 000B00 -> signal_window_o[0..9] = 000B, 000A, …, 0002; sample 0001 is evicted.
- Overrun: second sample_valid_i at T+5 -> dropped_o pulses at T+6; window and tapnum sequence are unchanged; frame_done_o still at T+12.
- Band clamp: eq_sel_i=8'hFF -> tap_o=16'h2000 for all 10 taps (band 3); changing eq_sel_i to 1 mid-frame has no effect.
- Mid-frame reset: assert rst_i while tapnum_o=5 -> next cycle state IDLE, busy_o=0, mac_en_o=0, window all 0, no frame_done_o pulse.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types, default sizes and coefficient table for the FIR tap sequencer.
package fir_pkg;

    localparam int NTAPS_DEF    = 10;
    localparam int NBANDS_DEF   = 4;
    localparam int DATA_W_DEF   = 16;
    localparam int SAMPLE_W_DEF = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Signed Q15 coefficient sets, one row per equalizer band.
    localparam logic [15:0] COEFF [NBANDS_DEF][NTAPS_DEF] = '{
        '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
          16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
        '{16'h0CCD, 16'h0CCD, 16'h0CCD, 16'h0CCD, 16'h0CCD,
          16'h0CCD, 16'h0CCD, 16'h0CCD, 16'h0CCD, 16'h0CCD},
        '{16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000,
          16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
        '{16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000,
          16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000}
    };

endpackage

// File: rtl/fir_coeff_rom.sv
// Coefficient ROM addressed by {band, tap}; read data appears one cycle after
// a read is enabled and holds while no read is requested.
module fir_coeff_rom
    import fir_pkg::*;
#(
    parameter int NTAPS  = NTAPS_DEF,
    parameter int NBANDS = NBANDS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BAND_W = 2,
    parameter int TAP_W  = 4
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      rd_en,
    input  logic [BAND_W+TAP_W-1:0]   addr,
    output logic [DATA_W-1:0]         dout
);

    localparam int ADDR_W = BAND_W + TAP_W;
    localparam int DEPTH  = 1 << ADDR_W;

    logic [DATA_W-1:0] rom_mem [DEPTH];
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] dout_q;

    // Flatten the coefficient table into a power-of-two address space; unused
    // tap slots of each band read as zero.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
            localparam int B = gi >> TAP_W;
            localparam int T = gi % (1 << TAP_W);
            if (B < NBANDS && B < NBANDS_DEF && T < NTAPS && T < NTAPS_DEF) begin : g_used
                assign rom_mem[gi] = DATA_W'(COEFF[B][T]);
            end else begin : g_pad
                assign rom_mem[gi] = '0;
            end
        end
    endgenerate

    // Next read data: fetch on enable, otherwise hold the last word.
    always_comb begin
        dout_d = dout_q;
        if (rd_en) begin
            dout_d = rom_mem[addr];
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (srst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sample window and per-tap coefficient sequencer feeding the FIR MAC stage.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS    = NTAPS_DEF,
    parameter int NBANDS   = NBANDS_DEF,
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      sample_valid_i,
    input  logic [SAMPLE_W-1:0]       sample_i,
    input  logic [7:0]                eq_sel_i,
    output logic [NTAPS*DATA_W-1:0]   signal_window_o,
    output logic [DATA_W-1:0]         tap_o,
    output logic [7:0]                tapnum_o,
    output logic                      mac_en_o,
    output logic                      busy_o,
    output logic                      frame_done_o,
    output logic                      dropped_o
);

    localparam int BAND_W = (NBANDS > 1) ? $clog2(NBANDS) : 1;
    // Read pointer runs one past the last tap, so size it for NTAPS.
    localparam int TAP_W  = $clog2(NTAPS + 1);
    localparam logic [7:0] LAST_TAP = 8'(NTAPS - 1);
    localparam logic [7:0] MAX_BAND = 8'(NBANDS - 1);

    seq_state_t        state_q, state_d;
    logic [DATA_W-1:0] window_q [NTAPS];
    logic [DATA_W-1:0] window_d [NTAPS];
    logic [BAND_W-1:0] band_q, band_d;
    logic [TAP_W-1:0]  rd_tap_q, rd_tap_d;
    logic [7:0]        tapnum_q, tapnum_d;
    logic              mac_en_q, mac_en_d;
    logic              frame_done_q, frame_done_d;
    logic              dropped_q, dropped_d;
    logic              rom_en;

    // Only the top DATA_W bits of each sample enter the window.
    logic unused_sample_bits;
    assign unused_sample_bits = ^sample_i[SAMPLE_W-DATA_W-1:0];

    // Next-state logic: accept in IDLE, one priming cycle for the ROM, then
    // one tap per cycle with the ROM addressed one tap ahead.
    always_comb begin
        state_d      = state_q;
        window_d     = window_q;
        band_d       = band_q;
        rd_tap_d     = rd_tap_q;
        tapnum_d     = tapnum_q;
        mac_en_d     = 1'b0;
        frame_done_d = 1'b0;
        dropped_d    = 1'b0;
        rom_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_valid_i) begin
                    for (int k = NTAPS - 1; k > 0; k--) begin
                        window_d[k] = window_q[k-1];
                    end
                    window_d[0] = sample_i[SAMPLE_W-1 -: DATA_W];
                    band_d   = (eq_sel_i > MAX_BAND) ? MAX_BAND[BAND_W-1:0]
                                                     : eq_sel_i[BAND_W-1:0];
                    rd_tap_d = '0;
                    state_d  = PRIME;
                end
            end
            PRIME: begin
                rom_en   = 1'b1;
                rd_tap_d = rd_tap_q + TAP_W'(1);
                tapnum_d = 8'd0;
                mac_en_d = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                if (tapnum_q == LAST_TAP) begin
                    frame_done_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    rom_en   = 1'b1;
                    rd_tap_d = rd_tap_q + TAP_W'(1);
                    tapnum_d = tapnum_q + 8'd1;
                    mac_en_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Any sample offered outside IDLE is discarded and flagged.
        if (sample_valid_i && state_q != IDLE) begin
            dropped_d = 1'b1;
        end
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            for (int k = 0; k < NTAPS; k++) begin
                window_q[k] <= '0;
            end
            band_q       <= '0;
            rd_tap_q     <= '0;
            tapnum_q     <= '0;
            mac_en_q     <= 1'b0;
            frame_done_q <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            window_q     <= window_d;
            band_q       <= band_d;
            rd_tap_q     <= rd_tap_d;
            tapnum_q     <= tapnum_d;
            mac_en_q     <= mac_en_d;
            frame_done_q <= frame_done_d;
            dropped_q    <= dropped_d;
        end
    end

    fir_coeff_rom #(
        .NTAPS  (NTAPS),
        .NBANDS (NBANDS),
        .DATA_W (DATA_W),
        .BAND_W (BAND_W),
        .TAP_W  (TAP_W)
    ) u_rom (
        .clk   (clk_i),
        .srst  (rst_i),
        .rd_en (rom_en),
        .addr  ({band_q, rd_tap_q}),
        .dout  (tap_o)
    );

    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_win
            assign signal_window_o[gi*DATA_W +: DATA_W] = window_q[gi];
        end
    endgenerate

    assign tapnum_o     = tapnum_q;
    assign mac_en_o     = mac_en_q;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = frame_done_q;
    assign dropped_o    = dropped_q;

endmodule
